// File: rtl/if_fetch_ctrl_if.sv
// Fetch sequencer bundle: control inputs, instruction bus and FIFO write side.
// master = fetch controller, slave = surrounding bus/FIFO environment.
interface if_fetch_ctrl_if;
    logic        fetch_en;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        fifo_jmp;
    logic        fifo_jmp_addr_bit1;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_full;
    logic        busy;

    modport master (
        input  fetch_en, jmp, jmp_addr,
        input  ibus_gnt, ibus_rvalid, ibus_rdata, fifo_full,
        output ibus_req, ibus_addr,
        output fifo_jmp, fifo_jmp_addr_bit1,
        output fifo_wr_en, fifo_wr_data, busy
    );

    modport slave (
        output fetch_en, jmp, jmp_addr,
        output ibus_gnt, ibus_rvalid, ibus_rdata, fifo_full,
        input  ibus_req, ibus_addr,
        input  fifo_jmp, fifo_jmp_addr_bit1,
        input  fifo_wr_en, fifo_wr_data, busy
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: credit-limited bus requests, skid buffer,
// in-order FIFO writes and jump flush with in-flight discard tracking.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input logic             clk,
    input logic             rstb,
    if_fetch_ctrl_if.master bus
);
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam logic [31:0] PC_RST = {RESET_ADDR[31:2], 2'b00};

    logic [31:0]         pc_q, pc_d;
    logic [CW-1:0]       out_q, out_d;
    logic [CW-1:0]       disc_q, disc_d;
    logic [CW-1:0]       skid_cnt_q, skid_cnt_d;
    logic [DEPTH*32-1:0] skid_q, skid_d;
    logic [CW:0]         used;
    logic [CW-1:0]       wpos;
    logic                credit_ok;
    logic                grant;
    logic                keep;
    logic                bypass;
    logic                push;
    logic                drain;
    logic                unused_bit0;

    assign unused_bit0 = bus.jmp_addr[0];

    assign used      = {1'b0, out_q} + {1'b0, skid_cnt_q};
    assign credit_ok = used < (CW+1)'(DEPTH);

    assign bus.ibus_req  = bus.fetch_en & ~bus.jmp & credit_ok;
    assign bus.ibus_addr = pc_q;
    assign grant         = bus.ibus_req & bus.ibus_gnt;

    // Words still owed to a flushed stream never reach the FIFO.
    assign keep   = bus.ibus_rvalid & (disc_q == '0) & ~bus.jmp;
    assign bypass = keep & (skid_cnt_q == '0) & ~bus.fifo_full;
    assign push   = keep & ~bypass;
    assign drain  = (skid_cnt_q != '0) & ~bus.fifo_full & ~bus.jmp;

    assign bus.fifo_wr_en   = bypass | drain;
    assign bus.fifo_wr_data = drain  ? skid_q[31:0] :
                              bypass ? bus.ibus_rdata : '0;

    assign bus.fifo_jmp           = bus.jmp;
    assign bus.fifo_jmp_addr_bit1 = bus.jmp_addr[1];
    assign bus.busy = (out_q != '0) | (skid_cnt_q != '0);

    always_comb begin
        pc_d       = pc_q;
        out_d      = out_q + CW'(grant) - CW'(bus.ibus_rvalid);
        disc_d     = disc_q;
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        wpos       = skid_cnt_q - CW'(drain);

        if (bus.ibus_rvalid && disc_q != '0)
            disc_d = disc_q - CW'(1);

        if (drain) begin
            skid_d     = skid_q >> 32;
            skid_cnt_d = skid_cnt_q - CW'(1);
        end

        // Tail slot is computed after the pop so order stays strict.
        if (push) begin
            for (int i = 0; i < DEPTH; i++)
                if (wpos == CW'(i))
                    skid_d[i*32 +: 32] = bus.ibus_rdata;
            skid_cnt_d = skid_cnt_d + CW'(1);
        end

        if (grant)
            pc_d = pc_q + 32'd4;

        if (bus.jmp) begin
            pc_d       = {bus.jmp_addr[31:2], 2'b00};
            skid_cnt_d = '0;
            disc_d     = out_q - CW'(bus.ibus_rvalid);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pc_q       <= PC_RST;
            out_q      <= '0;
            disc_q     <= '0;
            skid_cnt_q <= '0;
            skid_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            skid_cnt_q <= skid_cnt_d;
            skid_q     <= skid_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed scenarios push expected grant
// addresses and FIFO words; a negedge monitor pops and compares them.
module tb_if_fetch_ctrl;
    logic clk = 1'b0;
    logic rstb;
    logic resp_en;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_w[$];
    logic [31:0] pend[$];

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(
        .RESET_ADDR (32'h0000_0100),
        .DEPTH      (2)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.busy), 32'd0);
        chk({name, "_sb"}, 32'(exp_a.size() + exp_w.size()), 32'd0);
        step();
    endtask

    // Bus responder: one-cycle latency, in order, gated by resp_en.
    always @(posedge clk) begin
        #1;
        if (!rstb) begin
            pend.delete();
            bus.ibus_rvalid = 1'b0;
            bus.ibus_rdata  = '0;
        end else begin
            if (bus.ibus_rvalid && pend.size() > 0)
                void'(pend.pop_front());
            if (resp_en && pend.size() > 0) begin
                bus.ibus_rvalid = 1'b1;
                bus.ibus_rdata  = dat(pend[0]);
            end else begin
                bus.ibus_rvalid = 1'b0;
                bus.ibus_rdata  = '0;
            end
        end
    end

    // Monitor: grants and FIFO writes against the scoreboard queues.
    always @(negedge clk) begin
        if (rstb) begin
            if (bus.ibus_req && bus.ibus_gnt) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_grant: got %h expected none",
                             bus.ibus_addr);
                end else begin
                    chk("grant_addr", bus.ibus_addr, exp_a.pop_front());
                end
                pend.push_back(bus.ibus_addr);
            end
            if (bus.fifo_wr_en) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_write: got %h expected none",
                             bus.fifo_wr_data);
                end else begin
                    chk("fifo_word", bus.fifo_wr_data, exp_w.pop_front());
                end
            end
            if (bus.jmp)
                chk("wr_in_jmp", 32'(bus.fifo_wr_en), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rstb            = 1'b0;
        resp_en         = 1'b1;
        bus.fetch_en    = 1'b0;
        bus.jmp         = 1'b0;
        bus.jmp_addr    = '0;
        bus.ibus_gnt    = 1'b1;
        bus.ibus_rvalid = 1'b0;
        bus.ibus_rdata  = '0;
        bus.fifo_full   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.ibus_req), 32'd0);
        chk("rst_addr", bus.ibus_addr, 32'h100);
        chk("rst_wr", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_wdata", bus.fifo_wr_data, 32'd0);
        chk("rst_jmp", 32'(bus.fifo_jmp), 32'd0);
        chk("rst_bit1", 32'(bus.fifo_jmp_addr_bit1), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        step();
        rstb = 1'b1;
        step();

        // Streaming at one word per cycle after a 1-cycle startup.
        for (int i = 0; i < 6; i++) begin
            exp_a.push_back(32'h100 + 32'(i * 4));
            exp_w.push_back(dat(32'h100 + 32'(i * 4)));
        end
        bus.fetch_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("s_req", 32'(bus.ibus_req), 32'd1);
            chk("s_wr", 32'(bus.fifo_wr_en), (k >= 2) ? 32'd1 : 32'd0);
            step();
        end
        bus.fetch_en = 1'b0;
        wait_idle("stream_idle");

        // FIFO full: skid fills to two, requests stop, drain in order.
        exp_a.push_back(32'h118);
        exp_a.push_back(32'h11C);
        exp_a.push_back(32'h120);
        exp_a.push_back(32'h124);
        exp_w.push_back(dat(32'h118));
        exp_w.push_back(dat(32'h11C));
        exp_w.push_back(dat(32'h120));
        exp_w.push_back(dat(32'h124));
        bus.fetch_en = 1'b1;
        step();
        step();
        bus.fifo_full = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("full_req", 32'(bus.ibus_req), 32'd0);
        chk("full_busy", 32'(bus.busy), 32'd1);
        step();
        step();
        step();
        bus.fifo_full = 1'b0;
        @(negedge clk);
        chk("drain_wr", 32'(bus.fifo_wr_en), 32'd1);
        chk("drain_req", 32'(bus.ibus_req), 32'd0);
        step();
        @(negedge clk);
        chk("resume_req", 32'(bus.ibus_req), 32'd1);
        step();
        bus.fetch_en = 1'b0;
        wait_idle("full_idle");

        // Jump with two requests in flight; both responses dropped.
        exp_a.push_back(32'h128);
        exp_a.push_back(32'h12C);
        exp_a.push_back(32'h2000);
        exp_a.push_back(32'h2004);
        exp_w.push_back(dat(32'h2000));
        exp_w.push_back(dat(32'h2004));
        resp_en      = 1'b0;
        bus.fetch_en = 1'b1;
        step();
        step();
        bus.jmp      = 1'b1;
        bus.jmp_addr = 32'h2002;
        resp_en      = 1'b1;
        @(negedge clk);
        chk("j2_fjmp", 32'(bus.fifo_jmp), 32'd1);
        chk("j2_bit1", 32'(bus.fifo_jmp_addr_bit1), 32'd1);
        chk("j2_req", 32'(bus.ibus_req), 32'd0);
        step();
        bus.jmp = 1'b0;
        @(negedge clk);
        chk("j2_disc_wr", 32'(bus.fifo_wr_en), 32'd0);
        step();
        step();
        step();
        bus.fetch_en = 1'b0;
        wait_idle("jmp2_idle");

        // Jump coinciding with the only response.
        exp_a.push_back(32'h2008);
        exp_a.push_back(32'h3000);
        exp_w.push_back(dat(32'h3000));
        bus.fetch_en = 1'b1;
        step();
        bus.jmp      = 1'b1;
        bus.jmp_addr = 32'h3000;
        @(negedge clk);
        chk("j1_wr", 32'(bus.fifo_wr_en), 32'd0);
        chk("j1_fjmp", 32'(bus.fifo_jmp), 32'd1);
        chk("j1_bit1", 32'(bus.fifo_jmp_addr_bit1), 32'd0);
        chk("j1_req", 32'(bus.ibus_req), 32'd0);
        step();
        bus.jmp = 1'b0;
        @(negedge clk);
        chk("j1_next_req", 32'(bus.ibus_req), 32'd1);
        step();
        bus.fetch_en = 1'b0;
        wait_idle("jmp1_idle");

        // Grant withheld: request and address held, pc steps once.
        exp_a.push_back(32'h3004);
        exp_w.push_back(dat(32'h3004));
        bus.ibus_gnt = 1'b0;
        bus.fetch_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_req", 32'(bus.ibus_req), 32'd1);
            chk("hold_addr", bus.ibus_addr, 32'h3004);
            step();
        end
        bus.ibus_gnt = 1'b1;
        step();
        bus.fetch_en = 1'b0;
        @(negedge clk);
        chk("hold_pc", bus.ibus_addr, 32'h3008);
        chk("fe_off_req", 32'(bus.ibus_req), 32'd0);
        wait_idle("hold_idle");

        // PC wrap at the top of the address space.
        exp_a.push_back(32'hFFFF_FFFC);
        exp_a.push_back(32'h0000_0000);
        exp_w.push_back(dat(32'hFFFF_FFFC));
        exp_w.push_back(dat(32'h0000_0000));
        bus.jmp      = 1'b1;
        bus.jmp_addr = 32'hFFFF_FFFC;
        bus.fetch_en = 1'b1;
        @(negedge clk);
        chk("wrap_jreq", 32'(bus.ibus_req), 32'd0);
        step();
        bus.jmp = 1'b0;
        step();
        step();
        bus.fetch_en = 1'b0;
        @(negedge clk);
        chk("wrap_pc", bus.ibus_addr, 32'h0000_0004);
        wait_idle("wrap_idle");

        // Reset mid-stream, then fetch restarts from the reset address.
        exp_a.push_back(32'h0000_0004);
        exp_a.push_back(32'h0000_0008);
        exp_w.push_back(dat(32'h0000_0004));
        bus.fetch_en = 1'b1;
        step();
        step();
        rstb         = 1'b0;
        bus.fetch_en = 1'b0;
        step();
        @(negedge clk);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_req", 32'(bus.ibus_req), 32'd0);
        chk("mrst_addr", bus.ibus_addr, 32'h100);
        chk("mrst_wr", 32'(bus.fifo_wr_en), 32'd0);
        step();
        rstb = 1'b1;
        exp_a.push_back(32'h100);
        exp_w.push_back(dat(32'h100));
        step();
        bus.fetch_en = 1'b1;
        step();
        bus.fetch_en = 1'b0;
        wait_idle("mrst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
